// File: rtl/stage_sequencer_pkg.sv
// Shared types for the program/compile/run sequencer.
//   seq_state_t : sequencer FSM states
//   stage_t     : effective stage presented to the address muxes
//   seq_err_t   : sticky error codes reported on err
// Helper functions map a stage request or FSM state to its stage/idle state.
package stage_sequencer_pkg;

  typedef enum logic [2:0] {
    S_PROG      = 3'd0,
    S_CMPL_IDLE = 3'd1,
    S_CMPL_WAIT = 3'd2,
    S_RUN_IDLE  = 3'd3,
    S_RUN_WAIT  = 3'd4
  } seq_state_t;

  typedef enum logic [1:0] {
    PROGRAM = 2'd0,
    COMPILE = 2'd1,
    RUN     = 2'd2
  } stage_t;

  typedef enum logic [1:0] {
    NONE        = 2'd0,
    CMPL_TO     = 2'd1,
    RUN_INVALID = 2'd2,
    RUN_TO      = 2'd3
  } seq_err_t;

  // Idle state selected by the stage switches; the reserved code maps to PROG.
  function automatic seq_state_t idle_for(input logic [1:0] req);
    case (req)
      2'd1:    return S_CMPL_IDLE;
      2'd2:    return S_RUN_IDLE;
      default: return S_PROG;
    endcase
  endfunction

  // Stage driven while the FSM sits in a given state.
  function automatic stage_t stage_of(input seq_state_t st);
    case (st)
      S_CMPL_IDLE, S_CMPL_WAIT: return COMPILE;
      S_RUN_IDLE,  S_RUN_WAIT:  return RUN;
      default:                  return PROGRAM;
    endcase
  endfunction

endpackage

// File: rtl/stage_sequencer_rise_edge.sv
// Rising-edge detector for an already synchronised level.
//   clk   : system clock
//   rst   : asynchronous active-low reset (previous level cleared to 0)
//   level : input level
//   rise  : high for the cycle where level is 1 and was 0 on the previous cycle
module rise_edge (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise
);

  logic prev_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prev_reg <= 1'b0;
    else      prev_reg <= level;
  end

  assign rise = level & ~prev_reg;

endmodule

// File: rtl/stage_sequencer.sv
// Sequencer for the program/compile/run flow.
//   clk, rst     : system clock, asynchronous active-low reset
//   stage_req    : switch request (0 program, 1 compile, 2 run, 3 -> program)
//   compile_btn  : compile button level; rising edge starts a compile in CMPL_IDLE
//   run_btn      : run button level; rising edge starts a run in RUN_IDLE
//   rf_we_bar    : register-file write (active low); invalidates the image in PROG
//   cmpl_done    : compiler done level
//   exe_done     : execution finished pulse
//   stage        : registered effective stage for the address muxes
//   compile_go   : one-cycle compile strobe
//   run_go       : one-cycle run strobe
//   busy         : compile or run in flight
//   img_valid    : compiled image matches register-file contents
//   err          : sticky error code (seq_err_t)
module stage_sequencer
  import stage_sequencer_pkg::*;
#(
  parameter int TO_W = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] stage_req,
  input  logic       compile_btn,
  input  logic       run_btn,
  input  logic       rf_we_bar,
  input  logic       cmpl_done,
  input  logic       exe_done,
  output logic [1:0] stage,
  output logic       compile_go,
  output logic       run_go,
  output logic       busy,
  output logic       img_valid,
  output logic [1:0] err
);

  // The wait lasts 2^TO_W-1 cycles: timeout fires on the cycle the counter
  // would step onto all-ones.
  localparam logic [TO_W-1:0] WD_LAST = ~TO_W'(1);

  seq_state_t      state_reg, state_next;
  stage_t          stage_reg, stage_next;
  seq_err_t        err_reg, err_next;
  logic [TO_W-1:0] wd_reg, wd_next;
  logic            compile_go_reg, compile_go_next;
  logic            run_go_reg, run_go_next;
  logic            busy_reg, busy_next;
  logic            img_valid_reg, img_valid_next;
  logic            cmpl_rise, run_rise;
  logic            wd_sat;

  rise_edge u_cmpl_edge (
    .clk   (clk),
    .rst   (rst),
    .level (compile_btn),
    .rise  (cmpl_rise)
  );

  rise_edge u_run_edge (
    .clk   (clk),
    .rst   (rst),
    .level (run_btn),
    .rise  (run_rise)
  );

  assign wd_sat = (wd_reg == WD_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= S_PROG;
      stage_reg      <= PROGRAM;
      err_reg        <= NONE;
      wd_reg         <= '0;
      compile_go_reg <= 1'b0;
      run_go_reg     <= 1'b0;
      busy_reg       <= 1'b0;
      img_valid_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      stage_reg      <= stage_next;
      err_reg        <= err_next;
      wd_reg         <= wd_next;
      compile_go_reg <= compile_go_next;
      run_go_reg     <= run_go_next;
      busy_reg       <= busy_next;
      img_valid_reg  <= img_valid_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    err_next        = err_reg;
    wd_next         = '0;            // cleared on every state change / idle
    compile_go_next = 1'b0;
    run_go_next     = 1'b0;
    img_valid_next  = img_valid_reg;

    case (state_reg)
      S_PROG: begin
        state_next = idle_for(stage_req);
        if (!rf_we_bar) img_valid_next = 1'b0;
      end

      S_CMPL_IDLE: begin
        state_next = idle_for(stage_req);
        if (cmpl_rise) begin
          compile_go_next = 1'b1;
          img_valid_next  = 1'b0;
          err_next        = NONE;
          state_next      = S_CMPL_WAIT;
        end
      end

      S_RUN_IDLE: begin
        state_next = idle_for(stage_req);
        if (run_rise) begin
          if (img_valid_reg) begin
            run_go_next = 1'b1;
            err_next    = NONE;
            state_next  = S_RUN_WAIT;
          end else begin
            err_next    = RUN_INVALID;
            state_next  = S_RUN_IDLE;
          end
        end
      end

      // Done is checked before the watchdog so a coincident done wins.
      S_CMPL_WAIT: begin
        if (cmpl_done) begin
          img_valid_next = 1'b1;
          state_next     = idle_for(stage_req);
        end else if (wd_sat) begin
          err_next   = CMPL_TO;
          state_next = idle_for(stage_req);
        end else begin
          wd_next = wd_reg + 1'b1;
        end
      end

      S_RUN_WAIT: begin
        if (exe_done) begin
          state_next = idle_for(stage_req);
        end else if (wd_sat) begin
          err_next   = RUN_TO;
          state_next = idle_for(stage_req);
        end else begin
          wd_next = wd_reg + 1'b1;
        end
      end

      default: state_next = S_PROG;
    endcase

    // Stage and busy are registered copies of what the next state implies,
    // so they move together with the state register.
    stage_next = stage_of(state_next);
    busy_next  = (state_next == S_CMPL_WAIT) || (state_next == S_RUN_WAIT);
  end

  assign stage      = stage_reg;
  assign compile_go = compile_go_reg;
  assign run_go     = run_go_reg;
  assign busy       = busy_reg;
  assign img_valid  = img_valid_reg;
  assign err        = err_reg;

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer (TO_W=4, so a wait times out after 15 cycles).
// Expected strobes (kind + cycle) are queued when a button is driven and
// popped whenever the DUT raises compile_go or run_go.
module tb_stage_sequencer;

  localparam int TO_W = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] stage_req;
  logic       compile_btn, run_btn, rf_we_bar, cmpl_done, exe_done;
  logic [1:0] stage, err;
  logic       compile_go, run_go, busy, img_valid;

  typedef struct {
    logic [1:0] kind;   // {compile_go, run_go}
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   busy_cnt = 0;

  stage_sequencer #(.TO_W(TO_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .stage_req   (stage_req),
    .compile_btn (compile_btn),
    .run_btn     (run_btn),
    .rf_we_bar   (rf_we_bar),
    .cmpl_done   (cmpl_done),
    .exe_done    (exe_done),
    .stage       (stage),
    .compile_go  (compile_go),
    .run_go      (run_go),
    .busy        (busy),
    .img_valid   (img_valid),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expect a strobe on the cycle after the one in which the button is driven.
  task automatic expect_strobe(input logic [1:0] kind);
    exp_t e;
    e.kind = kind;
    e.cyc  = cyc + 1;
    exp_q.push_back(e);
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (busy) busy_cnt++;
    if (compile_go || run_go) begin
      if (exp_q.size() == 0) begin
        chk("strobe_unexpected", int'({compile_go, run_go}), 0);
      end else begin
        e = exp_q.pop_front();
        $display("strobe cyc=%0d compile_go=%0b run_go=%0b err=%0d", cyc, compile_go, run_go, err);
        chk("strobe_kind", int'({compile_go, run_go}), int'(e.kind));
        chk("strobe_cycle", cyc, e.cyc);
      end
    end
  endtask

  initial begin
    rst = 1'b0; stage_req = 2'd0; compile_btn = 1'b0; run_btn = 1'b0;
    rf_we_bar = 1'b1; cmpl_done = 1'b0; exe_done = 1'b0;

    // Reset values
    repeat (2) step();
    chk("rst_stage", int'(stage), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_img_valid", int'(img_valid), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_compile_go", int'(compile_go), 0);
    chk("rst_run_go", int'(run_go), 0);
    rst = 1'b1;
    step();

    // Run without a valid image
    stage_req = 2'd2; step();
    chk("run_stage", int'(stage), 2);
    run_btn = 1'b1; step(); run_btn = 1'b0; step();
    chk("run_invalid_err", int'(err), 2);
    chk("run_invalid_stage", int'(stage), 2);
    chk("run_invalid_busy", int'(busy), 0);
    stage_req = 2'd3; step();
    chk("reserved_stage", int'(stage), 0);

    // Compile, done after 10 cycles; a compile press mid-wait is discarded
    stage_req = 2'd1; step();
    chk("cmpl_stage", int'(stage), 1);
    busy_cnt = 0;
    compile_btn = 1'b1; expect_strobe(2'b10); step(); compile_btn = 1'b0;
    chk("cmpl_err_cleared", int'(err), 0);
    chk("cmpl_busy", int'(busy), 1);
    repeat (3) step();
    compile_btn = 1'b1; step(); compile_btn = 1'b0;
    repeat (6) step();
    chk("cmpl_img_invalid_during", int'(img_valid), 0);
    cmpl_done = 1'b1; step(); cmpl_done = 1'b0;
    chk("cmpl_busy_cycles", busy_cnt, 11);
    chk("cmpl_img_valid", int'(img_valid), 1);
    chk("cmpl_err", int'(err), 0);
    chk("cmpl_busy_low", int'(busy), 0);
    rf_we_bar = 1'b0; step(); rf_we_bar = 1'b1;
    chk("rf_we_ignored_outside_prog", int'(img_valid), 1);

    // Run; stage_req moves to 0 mid-run, stage holds 2 until exe_done
    stage_req = 2'd2; step();
    busy_cnt = 0;
    run_btn = 1'b1; expect_strobe(2'b01); step(); run_btn = 1'b0;
    stage_req = 2'd0;
    repeat (4) step();
    chk("run_stage_held", int'(stage), 2);
    chk("run_busy", int'(busy), 1);
    exe_done = 1'b1; step(); exe_done = 1'b0;
    chk("run_stage_after_done", int'(stage), 0);
    chk("run_busy_low", int'(busy), 0);
    chk("run_busy_cycles", busy_cnt, 5);
    chk("run_img_kept", int'(img_valid), 1);

    // Register-file write in PROG invalidates the image
    rf_we_bar = 1'b0; step(); rf_we_bar = 1'b1;
    chk("rf_we_invalidates", int'(img_valid), 0);
    stage_req = 2'd2; step();
    run_btn = 1'b1; step(); run_btn = 1'b0; step();
    chk("stale_run_err", int'(err), 2);
    chk("stale_run_busy", int'(busy), 0);

    // Compile timeout
    stage_req = 2'd1; step();
    busy_cnt = 0;
    compile_btn = 1'b1; expect_strobe(2'b10); step(); compile_btn = 1'b0;
    chk("to_err_cleared", int'(err), 0);
    repeat (14) step();
    chk("to_err_before", int'(err), 0);
    chk("to_busy_before", int'(busy), 1);
    step();
    chk("to_err", int'(err), 1);
    chk("to_busy_low", int'(busy), 0);
    chk("to_stage", int'(stage), 1);
    chk("to_busy_cycles", busy_cnt, 15);

    // New compile clears err; done coincident with timeout wins
    compile_btn = 1'b1; expect_strobe(2'b10); step(); compile_btn = 1'b0;
    chk("recompile_err_cleared", int'(err), 0);
    repeat (14) step();
    cmpl_done = 1'b1; step(); cmpl_done = 1'b0;
    chk("done_vs_to_err", int'(err), 0);
    chk("done_vs_to_img", int'(img_valid), 1);
    chk("done_vs_to_busy", int'(busy), 0);

    // Run timeout
    stage_req = 2'd2; step();
    run_btn = 1'b1; expect_strobe(2'b01); step(); run_btn = 1'b0;
    repeat (14) step();
    chk("run_to_err_before", int'(err), 0);
    step();
    chk("run_to_err", int'(err), 3);
    chk("run_to_busy", int'(busy), 0);
    chk("run_to_stage", int'(stage), 2);

    // Reset mid-compile aborts at once
    stage_req = 2'd1; step();
    compile_btn = 1'b1; expect_strobe(2'b10); step(); compile_btn = 1'b0;
    repeat (3) step();
    chk("mid_busy", int'(busy), 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_stage", int'(stage), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_img_valid", int'(img_valid), 0);
    chk("mid_rst_err", int'(err), 0);
    chk("mid_rst_compile_go", int'(compile_go), 0);
    step();
    rst = 1'b1;
    step();
    chk("post_rst_stage", int'(stage), 1);
    chk("post_rst_img_valid", int'(img_valid), 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
